// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared opcodes, state encoding and instruction field positions
package alu_op_sequencer_pkg;

  // ALU opcode select values (alu_c)
  localparam logic [2:0] OP_NEGA = 3'b000;
  localparam logic [2:0] OP_NEGB = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MULL = 3'b110;
  localparam logic [2:0] OP_MULH = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Instruction field bit positions; bit 9 selects LOAD vs ALU op
  localparam int INSTR_LOAD_BIT = 9;
  localparam int LD_RD_HI = 8;
  localparam int LD_RD_LO = 7;
  localparam int IMM_HI   = 3;
  localparam int IMM_LO   = 0;
  localparam int OPC_HI   = 8;
  localparam int OPC_LO   = 6;
  localparam int RD_HI    = 5;
  localparam int RD_LO    = 4;
  localparam int RS1_HI   = 3;
  localparam int RS1_LO   = 2;
  localparam int RS2_HI   = 1;
  localparam int RS2_LO   = 0;

endpackage

// File: rtl/alu_regfile4x4.sv
// rtl/alu_regfile4x4.sv - 4x4-bit register file, two operand reads, one debug read, one write
module alu_regfile4x4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [3:0] wdata,
  input  logic [1:0] raddr1,
  output logic [3:0] rdata1,
  input  logic [1:0] raddr2,
  output logic [3:0] rdata2,
  input  logic [1:0] dbg_sel,
  output logic [3:0] dbg_data
);

  logic [3:0] regs_q [4];

  // Storage: reset clears every entry and wins over a pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 4'd0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1   = regs_q[raddr1];
  assign rdata2   = regs_q[raddr2];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - instruction issue / write-back stage around the 4-bit ALU
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int INSTR_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [2:0]         alu_c,
  input  logic [3:0]         alu_out,
  output logic               res_valid,
  output logic [1:0]         res_rd,
  output logic [3:0]         res_data,
  input  logic [1:0]         dbg_sel,
  output logic [3:0]         dbg_data
);

  state_e     state_q, state_d;
  logic [1:0] rd_q;
  logic [3:0] result_q;
  logic [3:0] alu_a_q, alu_b_q;
  logic [2:0] alu_c_q;

  logic       accept;
  logic       is_load;
  logic [1:0] rs1, rs2, dst;
  logic [3:0] rs1_data, rs2_data;

  assign is_load = in_instr[INSTR_LOAD_BIT];
  assign rs1     = in_instr[RS1_HI:RS1_LO];
  assign rs2     = in_instr[RS2_HI:RS2_LO];
  assign dst     = is_load ? in_instr[LD_RD_HI:LD_RD_LO] : in_instr[RD_HI:RD_LO];
  assign accept  = in_valid & in_ready;

  alu_regfile4x4 u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (res_valid),
    .waddr    (rd_q),
    .wdata    (result_q),
    .raddr1   (rs1),
    .rdata1   (rs1_data),
    .raddr2   (rs2),
    .rdata2   (rs2_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // Next-state and handshake outputs; LOADs skip EXEC since the result is the immediate
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = is_load ? ST_WB : ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_EXEC == state_q ? ST_WB : ST_IDLE;
      ST_WB: begin
        res_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction latch, operand registers and result capture; operands are sampled at accept
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q     <= 2'd0;
      result_q <= 4'd0;
      alu_a_q  <= 4'd0;
      alu_b_q  <= 4'd0;
      alu_c_q  <= 3'd0;
    end else begin
      if (accept) begin
        rd_q <= dst;
        if (is_load) begin
          result_q <= in_instr[IMM_HI:IMM_LO];
        end else begin
          alu_a_q <= rs1_data;
          alu_b_q <= rs2_data;
          alu_c_q <= in_instr[OPC_HI:OPC_LO];
        end
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_out;
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_c    = alu_c_q;
  assign res_rd   = rd_q;
  assign res_data = result_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Instruction-issue and write-back stage wrapped around the 4-bit ALU. Accepts instruction words over a valid/ready handshake and keeps a 4-entry × 4-bit register file. It drives the ALU's `a`, `b` and `c` inputs and captures the ALU's 4-bit result, which it writes back to the register file and reports on a one-cycle result strobe. The ALU itself is instantiated beside this block (purely combinational); this block is its operand source and its result sink.

## Interface
- `INSTR_W`, 10: instruction word width (fixed format below; not meant to be overridden)
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high; clears all state
- `in_valid` in 1: instruction word present
- `in_ready` out 1: block can accept an instruction
- `in_instr` in 10: instruction word
- `alu_a` out 4: ALU operand a
- `alu_b` out 4: ALU operand b
- `alu_c` out 3: ALU opcode select
- `alu_out` in 4: ALU result (combinational from `alu_a`/`alu_b`/`alu_c`)
- `res_valid` out 1: one-cycle strobe, register written
- `res_rd` out 2: destination register index of the write
- `res_data` out 4: value written
- `dbg_sel` in 2: debug read index
- `dbg_data` out 4: combinational read of register `dbg_sel`

## Operation
- Instruction format:
  - `in_instr[9]` = 1 is a LOAD: `rd` = [8:7], `imm` = [3:0]; bits [6:4] are ignored.
  - `in_instr[9]` = 0 is an ALU op: `op` = [8:6], `rd` = [5:4], `rs1` = [3:2], `rs2` = [1:0].
- ALU op codes (meaning of `alu_c`):
  - 000: two's complement of a
  - 001: two's complement of b
  - 010: a+b, mod 16
  - 011: a−b, mod 16
  - 100: a AND b
  - 101: a OR b
  - 110: product[3:0]
  - 111: product[7:4]
- FSM states: IDLE, EXEC, WB.
  - IDLE: `in_ready`=1. On `in_valid`:
    - Latch the instruction.
    - For a LOAD, go to WB with result = imm.
    - For an ALU op, set `alu_a`←R[rs1], `alu_b`←R[rs2], `alu_c`←op and go to EXEC.
  - EXEC: `in_ready`=0. Capture `alu_out` into the result register, then go to WB.
  - WB: `in_ready`=0.
    - Write the result register to R[rd].
    - Assert `res_valid`=1 with `res_rd`=rd and `res_data`=result.
    - Go to IDLE.
- `alu_a`/`alu_b`/`alu_c` are registered. They hold their values from the accept edge until the next ALU-op accept; a LOAD does not change them.
- `rs1`, `rs2` and `rd` may alias (for example R1←R1+R1). Operands are sampled at accept, so aliasing is always safe.
- Ordering is strictly serial. The write in WB is complete before the next accept, so back-to-back dependent instructions read the updated value.
- `dbg_data` reflects a write starting in the cycle after the WB edge.
- All arithmetic is 4-bit, carries are dropped, and no flags are produced.

## Timing
- Reset values: all registers R0–R3 = 0, state = IDLE, `alu_a`/`alu_b`/`alu_c` = 0, `res_valid` = 0, `res_rd` = 0, `res_data` = 0, `in_ready` = 1 in the first cycle after reset.
- Latency is counted from the accept edge (`in_valid` & `in_ready` at edge N):
  - ALU op: `res_valid` is high during cycle N+2.
  - LOAD: `res_valid` is high during cycle N+1.
- Throughput: one ALU op per 3 cycles; one LOAD per 2 cycles.
- `in_valid` while `in_ready`=0 is ignored. The upstream holds the word; there is no drop and no error.
- `res_valid` is never high in two consecutive cycles.
- Reset asserted in any state:
  - The in-flight instruction is abandoned.
  - No `res_valid` is produced.
  - No register is written.
  - Reset takes priority over everything else.

## Structure
- A shared package holds:
  - the op-code localparams (OP_NEGA … OP_MULH)
  - the state encoding (IDLE/EXEC/WB)
  - instruction field bit positions
- One sub-module, `alu_regfile4x4`: 4×4-bit register file with two combinational read ports plus the debug read port (three reads total), one synchronous write port, and synchronous clear on reset.
- The FSM, instruction latch and result register live in the top of `alu_op_sequencer`.

## Test plan
- Reset, then LOAD R0=5 and LOAD R1=3.
  - Expect `res_valid` at accept+1 with (rd=0, 5), then (1, 3).
  - `dbg_sel`=0 reads 5.
- ADD R2=R0+R1 (op 010).
  - `alu_a`=5, `alu_b`=3, `alu_c`=010 during EXEC.
  - `res_valid` at accept+2 with rd=2, data=8.
- SUB R3=R1−R0 → 1110.
- NEGA R3←−R0 → 1011.
- OR of 0000 and 1101 → 1101.
- Multiply, with R0=6 and R1=15 loaded first:
  - op 110 → 1010.
  - op 111 → 0101.
- `in_valid` held high continuously with a 4-instruction stream.
  - Each word is accepted only in IDLE, and the accept count equals the `res_valid` count.
  - A dependent instruction (R1←R1+R1 repeated from R1=1) yields 2, 4, 8, 0.
- Assert reset during EXEC of an ADD.
  - No `res_valid` occurs.
  - All registers read 0.
  - `in_ready`=1 on the next cycle.
  - A subsequent LOAD works normally.
